// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} ser_state_t;

  localparam int SERIAL_SUB_DEF_WIDTH = 8;
endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of serial_subtractor.
// With SERIAL_SUB_OVF_EN defined the bundle also carries the signed-overflow flag.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEF_WIDTH
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input ready, done, diff, borrow_out, ovf);
    modport slave  (input start, a, b, output ready, done, diff, borrow_out, ovf);
`else
    modport master (output start, a, b, input ready, done, diff, borrow_out);
    modport slave  (input start, a, b, output ready, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - Bin, Bout = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic Bin,
    output logic d,
    output logic Bout
);
    assign d    = x ^ y ^ Bin;
    assign Bout = (~x & y) | (~(x ^ y) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first through one full_subtractor.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             brw, borrow_q, done_q;
    logic             cell_d, cell_bout;
    logic             last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, b_msb, ovf_q;
`endif

    full_subtractor u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .Bin  (brw),
        .d    (cell_d),
        .Bout (cell_bout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_SHIFT;
            S_SHIFT: if (last)      state_nxt = S_DONE;
            S_DONE:                 state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Results are registered on the edge leaving DONE, so done coincides with ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            brw      <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    a_sh <= bus.a;
                    b_sh <= bus.b;
                    d_sh <= '0;
                    brw  <= 1'b0;
                    cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb <= bus.a[WIDTH-1];
                    b_msb <= bus.b[WIDTH-1];
`endif
                end
                S_SHIFT: begin
                    d_sh <= {cell_d, d_sh[WIDTH-1:1]};
                    brw  <= cell_bout;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    if (!last) cnt <= cnt + CW'(1);
                end
                S_DONE: begin
                    diff_q   <= d_sh;
                    borrow_q <= brw;
                    done_q   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // d_sh MSB holds the final-cycle d bit.
                    ovf_q    <= (a_msb != b_msb) && (d_sh[WIDTH-1] != a_msb);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.ready      = (state == S_IDLE);
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf        = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed cases plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [7:0] diff;
        logic       brw;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Every bench cycle goes through here so done pulses are always scored.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus8.done === 1'b1) begin
            n_vec++;
            assert (q8.size() != 0) else begin
                n_miss++;
                $error("FAIL done8_unexpected: observed done=1 expected no pulse");
            end
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("diff8", 32'(bus8.diff), 32'(e.diff));
                check("borrow8", 32'(bus8.borrow_out), 32'(e.brw));
                check("latency8", 32'(cyc), 32'(e.due));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf8", 32'(bus8.ovf), 32'(e.ovf));
`endif
            end
        end
        if (bus4.done === 1'b1) begin
            n_vec++;
            assert (q4.size() != 0) else begin
                n_miss++;
                $error("FAIL done4_unexpected: observed done=1 expected no pulse");
            end
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("diff4", 32'(bus4.diff), 32'(e.diff));
                check("borrow4", 32'(bus4.borrow_out), 32'(e.brw));
                check("latency4", 32'(cyc), 32'(e.due));
            end
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input bit hold);
        exp_t e;
        int   g = 0;
        while (bus8.ready !== 1'b1 && g < 100) begin tick(); g++; end
        check("ready8_wait", 32'(bus8.ready), 32'd1);
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        e.diff = a - b;
        e.brw  = (a < b);
        e.ovf  = (a[7] != b[7]) && (e.diff[7] != a[7]);
        e.due  = cyc + 10;
        q8.push_back(e);
        tick();
        check("busy8", 32'(bus8.ready), 32'd0);
        if (!hold) bus8.start = 1'b0;
    endtask

    task automatic launch4(input logic [3:0] a, input logic [3:0] b, input bit hold);
        exp_t       e;
        logic [3:0] d4;
        int         g = 0;
        while (bus4.ready !== 1'b1 && g < 100) begin tick(); g++; end
        check("ready4_wait", 32'(bus4.ready), 32'd1);
        bus4.a     = a;
        bus4.b     = b;
        bus4.start = 1'b1;
        d4     = a - b;
        e.diff = {4'h0, d4};
        e.brw  = (a < b);
        e.ovf  = 1'b0;
        e.due  = cyc + 6;
        q4.push_back(e);
        tick();
        if (!hold) bus4.start = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q8.size() != 0 || q4.size() != 0) && g < 400) begin tick(); g++; end
        check("drain", 32'(q8.size() + q4.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        tick(); tick();
        check("rst_ready", 32'(bus8.ready), 32'd1);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_diff", 32'(bus8.diff), 32'd0);
        check("rst_borrow", 32'(bus8.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(bus8.ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();

        launch8(8'd5, 8'd3, 1'b0);
        drain();
        repeat (3) tick();
        check("diff8_held", 32'(bus8.diff), 32'h02);

        launch8(8'd3,   8'd5,   1'b0);
        launch8(8'd0,   8'd0,   1'b0);
        launch8(8'h80,  8'h01,  1'b0);
        launch8(8'h10,  8'h01,  1'b0);
        launch8(8'hFF,  8'h00,  1'b0);
        launch8(8'h00,  8'hFF,  1'b0);
        launch8(8'h7F,  8'h80,  1'b0);
        drain();

        // Start while busy must be ignored and yield a single result.
        launch8(8'd20, 8'd7, 1'b0);
        tick();
        bus8.a = 8'd9; bus8.start = 1'b1;
        check("busy_start_ready", 32'(bus8.ready), 32'd0);
        tick();
        bus8.start = 1'b0;
        drain();
        repeat (15) tick();
        check("busy_diff_held", 32'(bus8.diff), 32'h0D);

        // Reset mid-op: abort, clear outputs, no done pulse.
        bus8.a = 8'd50; bus8.b = 8'd10; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(bus8.ready), 32'd1);
        check("midrst_diff", 32'(bus8.diff), 32'd0);
        check("midrst_borrow", 32'(bus8.borrow_out), 32'd0);
        tick();
        rst = 1'b0;
        repeat (12) tick();
        launch8(8'd200, 8'd100, 1'b0);
        drain();
        check("post_rst_diff", 32'(bus8.diff), 32'd100);

        // Exhaustive WIDTH=4 sweep, start held high for back-to-back ops.
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                launch4(4'(ai), 4'(bi), 1'b1);
        bus4.start = 1'b0;
        drain();
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
